// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op field layout and FSM states.
package mdu_pkg;

    localparam logic OP_MUL    = 1'b0;
    localparam logic OP_DIV    = 1'b1;
    localparam int   OP_SIGNED = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mdu_datapath.sv
// Operand/accumulator shift registers and the one-bit-per-cycle step logic
// (shift-add multiply, restoring divide). Results are registered on finish.
// Optional signed support is compiled in with MDU_SIGNED_EN.
module mdu_datapath
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_by_zero
);

    // a_reg: multiplicand (MUL) or divisor (DIV)
    // hi:    partial product high half (MUL) or partial remainder (DIV)
    // lo:    multiplier shifting out (MUL) or dividend/quotient (DIV)
    logic [WIDTH-1:0] a_reg, hi, lo;
    logic             is_div, dbz;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] hi_n, lo_n, fix_hi, fix_lo;
    logic [WIDTH:0]   sum, shifted, trial;

`ifdef MDU_SIGNED_EN
    logic sgn, neg_q, neg_r;

    // Iteration works on magnitudes; signs are remembered and reapplied at the end.
    always_comb begin
        sgn   = op[OP_SIGNED];
        mag_a = (sgn && opa[WIDTH-1]) ? -opa : opa;
        mag_b = (sgn && opb[WIDTH-1]) ? -opb : opb;
    end

    // Result sign flags captured with the operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (load) begin
            neg_q <= sgn && (opa[WIDTH-1] ^ opb[WIDTH-1]);
            neg_r <= sgn && opa[WIDTH-1];
        end
    end
`else
    logic op_unused;
    assign op_unused = op[OP_SIGNED];
    assign mag_a     = opa;
    assign mag_b     = opb;
`endif

    // One iteration: add-and-shift-right for MUL, shift-left-and-trial-subtract for DIV.
    // A zero divisor always passes the trial, giving all-ones quotient and remainder = dividend.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, a_reg} : '0);
        shifted = {hi, lo[WIDTH-1]};
        trial   = shifted - {1'b0, a_reg};
        hi_n    = sum[WIDTH:1];
        lo_n    = {sum[0], lo[WIDTH-1:1]};
        if (is_div) begin
            if (!trial[WIDTH]) begin
                hi_n = trial[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = shifted[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Final result from the last step's output, with signs applied when enabled.
    always_comb begin
        fix_hi = hi_n;
        fix_lo = lo_n;
`ifdef MDU_SIGNED_EN
        if (!is_div) begin
            if (neg_q) {fix_hi, fix_lo} = -{hi_n, lo_n};
        end else begin
            if (neg_q && !dbz) fix_lo = -lo_n;
            if (neg_r)         fix_hi = -hi_n;
        end
`endif
    end

    // Operand capture on load, iteration on step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg  <= '0;
            hi     <= '0;
            lo     <= '0;
            is_div <= 1'b0;
            dbz    <= 1'b0;
        end else if (load) begin
            is_div <= (op[0] == OP_DIV);
            dbz    <= (op[0] == OP_DIV) && (opb == '0);
            hi     <= '0;
            a_reg  <= (op[0] == OP_DIV) ? mag_b : mag_a;
            lo     <= (op[0] == OP_DIV) ? mag_a : mag_b;
        end else if (step) begin
            hi <= hi_n;
            lo <= lo_n;
        end
    end

    // Visible results change only when an op completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_hi      <= '0;
            res_lo      <= '0;
            div_by_zero <= 1'b0;
        end else if (finish) begin
            res_hi      <= fix_hi;
            res_lo      <= fix_lo;
            div_by_zero <= dbz;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit: FSM, iteration counter and handshake.
// Signed operation is available when MDU_SIGNED_EN is defined.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             accept, last;

    assign accept = start && (state == S_IDLE || state == S_DONE);
    assign last   = (state == S_CALC) && (cnt == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state and handshake outputs; start during CALC is simply not looked at.
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE: if (start) state_n = S_CALC;
            S_CALC: begin
                busy = 1'b1;
                if (last) state_n = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = start ? S_CALC : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Iteration counter: cleared on accept, counts each CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 cnt <= '0;
        else if (accept)         cnt <= '0;
        else if (state == S_CALC) cnt <= last ? '0 : cnt + 1'b1;
    end

    mdu_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk         (clk),
        .rst         (rst),
        .load        (accept),
        .step        (state == S_CALC),
        .finish      (last),
        .op          (op),
        .opa         (opa),
        .opb         (opb),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (div_by_zero)
    );

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] opa = '0, opb = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] res_hi, res_lo;

    int tests = 0;
    int fails = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .opa         (opa),
        .opb         (opb),
        .busy        (busy),
        .done        (done),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: returns {div_by_zero, hi, lo}.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic   is_signed;
        longint sa, sb;
        is_signed = 1'b0;
`ifdef MDU_SIGNED_EN
        is_signed = o[1];
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o[0] == 1'b0) begin
            if (is_signed) return {1'b0, 64'(sa * sb)};
            return {1'b0, 64'(a) * 64'(b)};
        end
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (is_signed) return {1'b0, 32'(sa % sb), 32'(sa / sb)};
        return {1'b0, a % b, a / b};
    endfunction

    // Issue one op (accept edge counts as edge 1); lat = edges until done seen, -1 on timeout.
    // Operands are scrambled after acceptance; optionally pulse start mid-CALC.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int mid_at, output int lat, output int bcyc);
        @(negedge clk);
        op = o; opa = a; opb = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; opa = $urandom; opb = $urandom; op = 2'($urandom);
        lat = 1; bcyc = 0;
        while (!done && lat < 200) begin
            if (busy) bcyc++;
            start = (lat == mid_at);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, div_by_zero, res_hi, res_lo} !== '0) begin
            fails++; $display("FAIL reset_state: got %h expected 0", {busy, done, div_by_zero, res_hi, res_lo});
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({busy, done} !== 2'b00) begin
            fails++; $display("FAIL idle_after_reset: busy/done got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_mul_directed();
        int lat, bc;
        run_op(2'b00, 32'h0000_FFFF, 32'h0001_0000, 0, lat, bc);
        tests++;
        if (lat !== 33) begin fails++; $display("FAIL mul_latency: got %0d expected 33", lat); end
        tests++;
        if ({res_hi, res_lo} !== 64'h0000_0000_FFFF_0000) begin
            fails++; $display("FAIL mul_result: got %h expected 00000000ffff0000", {res_hi, res_lo});
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL done_pulse: done got %b expected 0", done); end
        tests++;
        if ({res_hi, res_lo} !== 64'h0000_0000_FFFF_0000) begin
            fails++; $display("FAIL mul_hold: got %h expected 00000000ffff0000", {res_hi, res_lo});
        end
    endtask

    task automatic test_div_directed();
        int lat, bc;
        run_op(2'b01, 32'd100, 32'd7, 0, lat, bc);
        tests++;
        if (lat !== 33) begin fails++; $display("FAIL div_latency: got %0d expected 33", lat); end
        tests++;
        if (bc !== 32) begin fails++; $display("FAIL div_busy_cycles: got %0d expected 32", bc); end
        tests++;
        if (res_lo !== 32'd14) begin fails++; $display("FAIL div_quot: got %0d expected 14", res_lo); end
        tests++;
        if (res_hi !== 32'd2) begin fails++; $display("FAIL div_rem: got %0d expected 2", res_hi); end
        tests++;
        if (div_by_zero !== 1'b0) begin fails++; $display("FAIL div_dbz_flag: got %b expected 0", div_by_zero); end
    endtask

    task automatic test_div_by_zero();
        int lat, bc;
        run_op(2'b01, 32'hA5A5_A5A5, 32'd0, 0, lat, bc);
        tests++;
        if (lat !== 33) begin fails++; $display("FAIL dbz_latency: got %0d expected 33", lat); end
        tests++;
        if (res_lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL dbz_quot: got %h expected ffffffff", res_lo); end
        tests++;
        if (res_hi !== 32'hA5A5_A5A5) begin fails++; $display("FAIL dbz_rem: got %h expected a5a5a5a5", res_hi); end
        tests++;
        if (div_by_zero !== 1'b1) begin fails++; $display("FAIL dbz_flag: got %b expected 1", div_by_zero); end
    endtask

    // Consecutive ops are issued during the previous DONE cycle, so these run back to back.
    task automatic test_random();
        int lat, bc;
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [64:0] exp;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 20));
                1:       b = 32'($urandom_range(0, 65535));
                default: b = $urandom;
            endcase
            exp = model(o, a, b);
            run_op(o, a, b, 0, lat, bc);
            tests++;
            if (lat !== 33) begin fails++; $display("FAIL rand_latency[%0d]: got %0d expected 33", i, lat); end
            tests++;
            if ({div_by_zero, res_hi, res_lo} !== exp) begin
                fails++;
                $display("FAIL rand_result[%0d] op=%b a=%h b=%h: got %h expected %h",
                         i, o, a, b, {div_by_zero, res_hi, res_lo}, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, bc;
        run_op(2'b00, 32'd12345, 32'd678, 0, lat1, bc);
        tests++;
        if ({res_hi, res_lo} !== 64'd8369910) begin
            fails++; $display("FAIL b2b_first: got %h expected %h", {res_hi, res_lo}, 64'd8369910);
        end
        run_op(2'b01, 32'd1000000, 32'd999, 0, lat2, bc);
        tests++;
        if (lat2 !== 33) begin fails++; $display("FAIL b2b_latency: got %0d expected 33", lat2); end
        tests++;
        if (res_lo !== 32'd1001 || res_hi !== 32'd1) begin
            fails++; $display("FAIL b2b_second: got q=%0d r=%0d expected q=1001 r=1", res_lo, res_hi);
        end
    endtask

    task automatic test_ignore_start();
        int lat, bc;
        run_op(2'b00, 32'hDEAD_BEEF, 32'h0000_1234, 10, lat, bc);
        tests++;
        if (lat !== 33) begin fails++; $display("FAIL ignore_latency: got %0d expected 33", lat); end
        tests++;
        if ({res_hi, res_lo} !== 64'hDEAD_BEEF * 64'h1234) begin
            fails++; $display("FAIL ignore_result: got %h expected %h", {res_hi, res_lo}, 64'hDEAD_BEEF * 64'h1234);
        end
    endtask

    task automatic test_async_reset();
        int lat, bc;
        run_op(2'b00, 32'd3, 32'd5, 0, lat, bc);
        tests++;
        if (res_lo !== 32'd15) begin fails++; $display("FAIL pre_reset_result: got %0d expected 15", res_lo); end
        @(negedge clk);
        op = 2'b00; opa = 32'd77; opb = 32'd99; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        tests++;
        if ({busy, done} !== 2'b00) begin fails++; $display("FAIL async_rst_ctrl: got %b expected 00", {busy, done}); end
        tests++;
        if ({div_by_zero, res_hi, res_lo} !== '0) begin
            fails++; $display("FAIL async_rst_results: got %h expected 0", {div_by_zero, res_hi, res_lo});
        end
        @(negedge clk) rst = 1'b0;
        run_op(2'b01, 32'd1000, 32'd10, 0, lat, bc);
        tests++;
        if (lat !== 33) begin fails++; $display("FAIL post_rst_latency: got %0d expected 33", lat); end
        tests++;
        if (res_lo !== 32'd100 || res_hi !== 32'd0) begin
            fails++; $display("FAIL post_rst_result: got q=%0d r=%0d expected q=100 r=0", res_lo, res_hi);
        end
    endtask

`ifdef MDU_SIGNED_EN
    task automatic test_signed();
        int lat, bc;
        run_op(2'b11, -32'sd7, 32'd2, 0, lat, bc);
        tests++;
        if (res_lo !== 32'hFFFF_FFFD || res_hi !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL sdiv: got q=%h r=%h expected q=fffffffd r=ffffffff", res_lo, res_hi);
        end
        run_op(2'b10, -32'sd3, 32'd5, 0, lat, bc);
        tests++;
        if ({res_hi, res_lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
            fails++; $display("FAIL smul: got %h expected fffffffffffffff1", {res_hi, res_lo});
        end
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bc);
        tests++;
        if (res_lo !== 32'h8000_0000 || res_hi !== 32'h0) begin
            fails++; $display("FAIL sdiv_min: got q=%h r=%h expected q=80000000 r=0", res_lo, res_hi);
        end
        run_op(2'b11, -32'sd5, 32'd0, 0, lat, bc);
        tests++;
        if ({div_by_zero, res_hi, res_lo} !== {1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin
            fails++; $display("FAIL sdiv_zero: got %h expected 1fffffffbffffffff", {div_by_zero, res_hi, res_lo});
        end
        tests++;
        if (lat !== 33) begin fails++; $display("FAIL signed_latency: got %0d expected 33", lat); end
    endtask
`endif

    initial begin
        test_reset();
        test_mul_directed();
        test_div_directed();
        test_div_by_zero();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_async_reset();
`ifdef MDU_SIGNED_EN
        test_signed();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
